alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//   Shares one 16-bit ALU (ADD/SUB/MULT/RSHIFT) between two requesters, A and B.
//   - Round-robin grant; each requester uses a valid/ready handshake.
//   - Issues the granted op to the ALU with a start/done handshake.
//   - Guards the ALU with a timeout and returns the result with an ID and error flag.
//   Sits between the switch/UI front end and the ALU core on the 100 MHz domain.
// PARAMETERS
//   WIDTH    16  operand width; the result is 2*WIDTH (full MULT product)
//   TIMEOUT  64  max cycles in WAIT before an error response; must be >= 2
//   TW       localparam = $clog2(TIMEOUT); width of the timeout counter
// PORTS
//   CLK100MHZ    in   1        system clock, rising edge
//   SW4          in   1        reset: asynchronous, active-high
//   a_valid      in   1        requester A has an op
//   a_ready      out  1        A request accepted this cycle
//   a_op         in   2        A opcode (alu_pkg encoding)
//   a_x, a_y     in   WIDTH    A operands
//   b_valid/b_ready/b_op/b_x/b_y    same as A, for requester B
//   alu_start    out  1        one-cycle pulse: ALU must latch op/operands
//   alu_op       out  2        opcode to ALU
//   alu_x, alu_y out  WIDTH    operands to ALU
//   alu_done     in   1        ALU result valid (one-cycle pulse)
//   alu_result   in   2*WIDTH  ALU result
//   rsp_valid    out  1        response available
//   rsp_ready    in   1        consumer takes response
//   rsp_id       out  1        0 = A, 1 = B
//   rsp_data     out  2*WIDTH  result; 0 on error
//   rsp_err      out  1        1 = ALU timed out
//   busy         out  1        state != IDLE
// BEHAVIOUR
//   Reset (async, SW4=1):
//   - State IDLE; every output and internal register = 0.
//   - RR pointer = A; any in-flight op is dropped.
//   - alu_done arriving after reset is ignored.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. The block holds one transaction at a time.
//   IDLE:
//   - Only one requester valid: grant it.
//   - Both valid: grant the RR pointer's side.
//   - x_ready = grant, combinational; asserted only in IDLE.
//   - On x_valid && x_ready: latch op/x/y/id; pointer moves to the other side; go to ISSUE.
//   ISSUE:
//   - alu_start = 1 for exactly this cycle.
//   - alu_op/x/y driven from the latched regs and held stable until back in IDLE.
//   - Timer cleared; go to WAIT.
//   WAIT:
//   - alu_done: latch alu_result, err = 0, go to RESP.
//   - Timer == TIMEOUT-1 with no done: data = 0, err = 1, go to RESP.
//   - alu_done on the timeout cycle: done wins (err = 0).
//   - alu_done outside WAIT: ignored.
//   RESP:
//   - rsp_valid = 1; rsp_id/data/err held stable while rsp_ready = 0.
//   - On rsp_valid && rsp_ready: rsp_valid drops next cycle; go to IDLE.
//   - No new grant in the handshake cycle.
//   Latency (request accepted at edge N):
//   - alu_start high in cycle N+1.
//   - Earliest alu_done in cycle N+2.
//   - rsp_valid in cycle N+3.
//   - Minimum 4 cycles per transaction.
//   Arithmetic/widths:
//   - Result passed through unmodified, 2*WIDTH bits.
//   - The block does no arithmetic other than the TW-bit timer, which saturates (never wraps).
//   Requesters:
//   - Must hold valid and payload stable until ready.
//   - Dropping valid before ready is legal; no grant results.
// STRUCTURE
//   - Package alu_pkg: opcode enum (ADD=2'b00, SUB=2'b01, MULT=2'b10, RSHIFT=2'b11),
//     FSM state enum, RSP_ID_A/RSP_ID_B constants.
//   - Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance -> gnt[1:0], ptr),
//     with async reset to ptr = A.
//   - FSM, operand/response registers and timer live in alu_req_arbiter.
// TESTING
//   1. Single request, A ADD x=3 y=5; ALU model asserts done 1 cycle after start with 8.
//      -> alu_start 1 cycle after accept; rsp_valid 3 cycles after accept; rsp_id=0, data=8, err=0.
//   2. A and B both valid from reset, run 4 transactions -> grant order A, B, A, B;
//      alu_start never asserted while busy with a prior op.
//   3. Only B valid, 3 MULT ops 0xFFFF*0xFFFF -> all granted to B; rsp_data=0xFFFE0001 each time.
//   4. ALU model never asserts done -> rsp_err=1, rsp_data=0 exactly TIMEOUT cycles into WAIT.
//      Rerun with done on the timeout cycle -> err=0, data=ALU result.
//   5. Hold rsp_ready=0 for 10 cycles with A and B valid -> rsp outputs stable;
//      a_ready=b_ready=0; no alu_start.
//   6. Assert SW4 mid-WAIT -> all outputs 0 immediately (async); a later alu_done produces no
//      response; the next dual request is granted to A.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, FSM state and response-id definitions for alu_req_arbiter
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_MULT   = 2'b10,
    OP_RSHIFT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic RSP_ID_A = 1'b0;
  localparam logic RSP_ID_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; ptr names the side favoured on a tie
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (ptr == RSP_ID_B) ? 2'b10 : 2'b01;
  end

  // after a grant the other side becomes favoured
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ptr <= RSP_ID_A;
    else if (advance && (gnt != 2'b00)) ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one ALU between requesters A and B with timeout guard
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 CLK100MHZ,
  input  logic                 SW4,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [1:0]           a_op,
  input  logic [WIDTH-1:0]     a_x,
  input  logic [WIDTH-1:0]     a_y,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [1:0]           b_op,
  input  logic [WIDTH-1:0]     b_x,
  input  logic [WIDTH-1:0]     b_y,
  output logic                 alu_start,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  input  logic                 alu_done,
  input  logic [2*WIDTH-1:0]   alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e              state, state_n;
  alu_op_e             op_q;
  logic [WIDTH-1:0]    x_q, y_q;
  logic                id_q;
  logic [TW-1:0]       timer;
  logic [2*WIDTH-1:0]  data_q;
  logic                err_q;
  logic [1:0]          req, gnt;
  logic                ptr, accept, acc_id, timed_out;

  // requests are only visible to the arbiter while idle, so ready is idle-only
  assign req = (state == ST_IDLE) ? {b_valid, a_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk     (CLK100MHZ),
    .rst     (SW4),
    .req     (req),
    .advance (accept),
    .gnt     (gnt),
    .ptr     (ptr)
  );

  assign accept    = |gnt;
  assign acc_id    = (req == 2'b11) ? ptr : req[1];
  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign timed_out = (timer == TLAST);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_ISSUE;
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT:  if (alu_done || timed_out) state_n = ST_RESP;
      ST_RESP:  if (rsp_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge SW4) begin
    if (SW4) begin
      state  <= ST_IDLE;
      op_q   <= OP_ADD;
      x_q    <= '0;
      y_q    <= '0;
      id_q   <= RSP_ID_A;
      timer  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (accept) begin
          op_q <= alu_op_e'(acc_id ? b_op : a_op);
          x_q  <= acc_id ? b_x : a_x;
          y_q  <= acc_id ? b_y : a_y;
          id_q <= acc_id;
        end
        ST_ISSUE: timer <= '0;
        // done beats the timeout when both land in the same cycle
        ST_WAIT: if (alu_done) begin
          data_q <= alu_result;
          err_q  <= 1'b0;
        end else if (timed_out) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_start = (state == ST_ISSUE);
  assign alu_op    = op_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed self-checking bench for alu_req_arbiter
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        sw4 = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [1:0]  a_op = 2'b00, b_op = 2'b00;
  logic [15:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_x, alu_y;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // ALU model: done_at = WAIT cycle carrying done (1 = first), 0 = never
  int          done_at = 1;
  int          wcnt = 0;
  logic        active = 1'b0;
  logic        model_done = 1'b0;
  logic        tb_done = 1'b0;
  logic [31:0] model_res = '0;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .CLK100MHZ (clk),
    .SW4       (sw4),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_op      (a_op),
    .a_x       (a_x),
    .a_y       (a_y),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_op      (b_op),
    .b_x       (b_x),
    .b_y       (b_y),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  assign alu_done   = model_done | tb_done;
  assign alu_result = model_res;

  always @(negedge clk) begin
    logic [31:0] ex, ey;
    model_done = 1'b0;
    if (alu_start) begin
      active = 1'b1;
      wcnt   = 0;
      ex     = {16'h0, alu_x};
      ey     = {16'h0, alu_y};
      case (alu_op)
        2'b00:   model_res = ex + ey;
        2'b01:   model_res = ex - ey;
        2'b10:   model_res = ex * ey;
        default: model_res = ex >> alu_y;
      endcase
    end else if (active) begin
      wcnt = wcnt + 1;
      if (done_at != 0 && wcnt == done_at) begin
        model_done = 1'b1;
        active     = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Entered 2 time units after an edge, in IDLE, with requests already driven.
  task automatic run_txn(input logic exp_b, input logic [15:0] exp_x, input logic [31:0] exp_data);
    #1;
    check("grant", {b_ready, a_ready}, exp_b ? 2'b10 : 2'b01);
    tick;
    check("start_n1", {alu_start, alu_x, busy}, {1'b1, exp_x, 1'b1});
    tick;
    check("wait_n2", {alu_start, rsp_valid}, 2'b00);
    tick;
    check("rsp_n3", {rsp_valid, rsp_id, rsp_data, rsp_err, a_ready, b_ready, alu_start},
          {1'b1, exp_b, exp_data, 1'b0, 1'b0, 1'b0, 1'b0});
    tick;
  endtask

  initial begin
    int n;
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    tick;
    tick;
    #1;
    check("reset_outs", {a_ready, b_ready, alu_start, alu_op, alu_x, alu_y, rsp_valid,
          rsp_id, rsp_data, rsp_err, busy}, 73'h0);

    // both requesters valid from reset: A, B, A, B
    a_op = 2'b00; a_x = 16'd1;  a_y = 16'd2;
    b_op = 2'b01; b_x = 16'd10; b_y = 16'd4;
    rsp_ready = 1'b1;
    tick;
    sw4 = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    run_txn(1'b0, 16'd1, 32'd3);
    run_txn(1'b1, 16'd10, 32'd6);
    run_txn(1'b0, 16'd1, 32'd3);
    run_txn(1'b1, 16'd10, 32'd6);
    a_valid = 1'b0; b_valid = 1'b0;
    tick;
    check("idle_after_rr", {busy, rsp_valid, alu_start}, 3'b000);

    // single A ADD 3 + 5
    a_op = 2'b00; a_x = 16'd3; a_y = 16'd5; a_valid = 1'b1;
    run_txn(1'b0, 16'd3, 32'd8);
    a_valid = 1'b0;
    tick;

    // only B, three MULT 0xFFFF * 0xFFFF
    b_op = 2'b10; b_x = 16'hFFFF; b_y = 16'hFFFF; b_valid = 1'b1;
    run_txn(1'b1, 16'hFFFF, 32'hFFFE0001);
    run_txn(1'b1, 16'hFFFF, 32'hFFFE0001);
    run_txn(1'b1, 16'hFFFF, 32'hFFFE0001);
    b_valid = 1'b0;
    tick;

    // timeout: ALU never answers
    done_at = 0; rsp_ready = 1'b0;
    a_op = 2'b00; a_x = 16'd7; a_y = 16'd9; a_valid = 1'b1;
    #1;
    check("to_grant", {b_ready, a_ready}, 2'b01);
    tick;
    a_valid = 1'b0;
    check("to_start", alu_start, 1'b1);
    tick;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick;
      n++;
    end
    check("to_latency", n, 64);
    check("to_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, 1'b0, 32'h0, 1'b1});

    // response back-pressure with both requesters waiting
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("hold_stable", {rsp_valid, rsp_id, rsp_data, rsp_err, a_ready, b_ready, alu_start},
            {1'b1, 1'b0, 32'h0, 1'b1, 3'b000});
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_no_grant", {a_ready, b_ready}, 2'b00);
    tick;
    check("post_hs_grant_b", {rsp_valid, b_ready, a_ready}, 3'b010);
    a_valid = 1'b0; b_valid = 1'b0;
    rsp_ready = 1'b0;
    tick;
    check("withdrawn_no_grant", {busy, alu_start}, 2'b00);

    // done on the timeout cycle wins
    done_at = 64;
    b_op = 2'b10; b_x = 16'h0100; b_y = 16'h0010; b_valid = 1'b1;
    #1;
    check("td_grant", {b_ready, a_ready}, 2'b10);
    tick;
    b_valid = 1'b0;
    tick;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick;
      n++;
    end
    check("td_latency", n, 64);
    check("td_rsp", {rsp_valid, rsp_id, rsp_data, rsp_err}, {1'b1, 1'b1, 32'h00001000, 1'b0});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    tick;

    // asynchronous reset mid-WAIT
    done_at = 0;
    a_op = 2'b11; a_x = 16'h8000; a_y = 16'd4; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    tick;
    tick;
    tick;
    check("mid_wait_busy", {busy, rsp_valid}, 2'b10);
    sw4 = 1'b1;
    #1;
    check("async_reset_outs", {a_ready, b_ready, alu_start, alu_op, alu_x, alu_y, rsp_valid,
          rsp_id, rsp_data, rsp_err, busy}, 73'h0);
    tick;
    sw4 = 1'b0;
    tick;
    tb_done = 1'b1;
    tick;
    tb_done = 1'b0;
    check("late_done_ignored", {rsp_valid, busy}, 2'b00);
    tick;
    check("late_done_ignored2", {rsp_valid, busy}, 2'b00);

    done_at = 1; rsp_ready = 1'b1;
    a_op = 2'b00; a_x = 16'h1234; a_y = 16'h0001; a_valid = 1'b1;
    b_op = 2'b01; b_x = 16'h0009; b_y = 16'h0001; b_valid = 1'b1;
    run_txn(1'b0, 16'h1234, 32'h00001235);
    a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
